// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stall vector, branch flush/redirect, EX-stall watchdog.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned MAX_EX_STALL = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_mem_i,
    input  logic        stallreq_ex_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        ex_is_load_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        id_re1_i,
    input  logic [4:0]  id_ra1_i,
    input  logic        id_re2_i,
    input  logic [4:0]  id_ra2_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [1:0]  state_o,
    output logic        ex_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EXWAIT  = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_EX_STALL);

    state_t     state_q, state_d;
    logic [7:0] ex_cnt_q, ex_cnt_d;
    logic       timeout_q, timeout_d;
    logic       load_use;

    always_comb begin
        load_use = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                   ((id_re1_i & (id_ra1_i == ex_wd_i)) |
                    (id_re2_i & (id_ra2_i == ex_wd_i)));

        stall_o  = '0;
        flush_o  = 1'b0;
        new_pc_o = '0;
        // A MEM hold freezes the whole pipe, so the FSM keeps its state too.
        state_d  = state_q;

        if (rst) begin
            state_d = RUN;
        end else if (stallreq_mem_i) begin
            stall_o = 6'b011111;
        end else if (stallreq_ex_i) begin
            stall_o = 6'b001111;
            state_d = EXWAIT;
        end else if (branch_flag_i) begin
            flush_o  = 1'b1;
            new_pc_o = branch_target_i;
            state_d  = FLUSHED;
        end else begin
            state_d = RUN;
            // ID holds a killed instruction right after a flush; its hazard is not real.
            if (load_use && (state_q != FLUSHED)) begin
                stall_o = 6'b000111;
            end
        end
    end

    always_comb begin
        ex_cnt_d = ex_cnt_q;
        if (!stallreq_ex_i) begin
            ex_cnt_d = '0;
        end else if (!stallreq_mem_i && (ex_cnt_q != 8'hFF)) begin
            ex_cnt_d = ex_cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (ex_cnt_q >= MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            ex_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ex_cnt_q  <= ex_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o      = state_q;
    assign ex_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_o != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: expectations queued per step, compared mid-cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_mem_i, stallreq_ex_i, branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ex_is_load_i, ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic        id_re1_i, id_re2_i;
    logic [4:0]  id_ra1_i, id_ra2_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [1:0]  state_o;
    logic        ex_timeout_o;
    logic [31:0] stall_cycles_o, flush_count_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_EX_STALL(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_mem_i  (stallreq_mem_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_wreg_i       (ex_wreg_i),
        .ex_wd_i         (ex_wd_i),
        .id_re1_i        (id_re1_i),
        .id_ra1_i        (id_ra1_i),
        .id_re2_i        (id_re2_i),
        .id_ra2_i        (id_ra2_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .state_o         (state_o),
        .ex_timeout_o    (ex_timeout_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_count_o   (flush_count_o)
    );

    typedef struct {
        string       tag;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic [1:0]  s;
        logic        ck_s;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    localparam logic [1:0] S_RUN = 2'd0, S_EXW = 2'd1, S_FL = 2'd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] st, input logic fl,
                        input logic [31:0] pc, input logic [1:0] s, input logic ck_s,
                        input logic to);
        exp_t e;
        e.tag = tag; e.st = st; e.fl = fl; e.pc = pc; e.s = s; e.ck_s = ck_s; e.to = to;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".stall"}, 32'(stall_o), 32'(e.st));
        chk({e.tag, ".flush"}, 32'(flush_o), 32'(e.fl));
        chk({e.tag, ".new_pc"}, new_pc_o, e.pc);
        if (e.ck_s) chk({e.tag, ".state"}, 32'(state_o), 32'(e.s));
        chk({e.tag, ".timeout"}, 32'(ex_timeout_o), 32'(e.to));
`ifdef PIPE_CTRL_PERF_EN
        chk({e.tag, ".stall_cycles"}, stall_cycles_o, m_stall);
        chk({e.tag, ".flush_count"}, flush_count_o, m_flush);
`else
        chk({e.tag, ".stall_cycles"}, stall_cycles_o, 32'd0);
        chk({e.tag, ".flush_count"}, flush_count_o, 32'd0);
`endif
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (e.st != 6'd0) m_stall = m_stall + 32'd1;
            if (e.fl) m_flush = m_flush + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stallreq_mem_i = 1'b0; stallreq_ex_i = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = '0; ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = '0;
        id_re1_i = 1'b0; id_ra1_i = '0; id_re2_i = 1'b0; id_ra2_i = '0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Hostile inputs while in reset must be ignored.
        stallreq_mem_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'hDEAD_BEEF;
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd5; id_re1_i = 1'b1; id_ra1_i = 5'd5;
        step("rst_hold", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        clr(); rst = 1'b0;
        step("idle", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd5; id_re1_i = 1'b1; id_ra1_i = 5'd5;
        step("lu_rs1", 6'b000111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        ex_is_load_i = 1'b0;
        step("lu_gone", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        ex_is_load_i = 1'b1; ex_wd_i = 5'd7; id_re1_i = 1'b0; id_ra1_i = 5'd7;
        id_re2_i = 1'b1; id_ra2_i = 5'd7;
        step("lu_rs2", 6'b000111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        id_re2_i = 1'b0;
        step("lu_re_off", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        ex_wd_i = 5'd0; id_re1_i = 1'b1; id_ra1_i = 5'd0;
        step("lu_x0", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        ex_wd_i = 5'd5; id_ra1_i = 5'd5; ex_wreg_i = 1'b0;
        step("lu_nowreg", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        ex_wreg_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h0000_0100;
        step("br_lu", 6'b000000, 1'b1, 32'h100, S_RUN, 1'b1, 1'b0);
        branch_flag_i = 1'b0;
        step("flushed_lu", 6'b000000, 1'b0, 32'h0, S_FL, 1'b1, 1'b0);
        step("lu_after_fl", 6'b000111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        clr();

        stallreq_mem_i = 1'b1; stallreq_ex_i = 1'b1; branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0300;
        step("mem_pri", 6'b011111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        stallreq_mem_i = 1'b0;
        step("ex_pri", 6'b001111, 1'b0, 32'h0, S_RUN, 1'b0, 1'b0);
        clr();
        step("ex_pri_drop", 6'b000000, 1'b0, 32'h0, S_EXW, 1'b1, 1'b0);
        step("idle2", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        stallreq_ex_i = 1'b1;
        for (int i = 0; i < 10; i++)
            step("exwait10", 6'b001111, 1'b0, 32'h0, (i == 0) ? S_RUN : S_EXW, 1'b1, 1'b0);
        stallreq_ex_i = 1'b0;
        step("ex_fall", 6'b000000, 1'b0, 32'h0, S_EXW, 1'b1, 1'b0);
        step("ex_done", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        stallreq_ex_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h0000_0200;
        step("ex_br_ign0", 6'b001111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        step("ex_br_ign1", 6'b001111, 1'b0, 32'h0, S_EXW, 1'b1, 1'b0);
        stallreq_ex_i = 1'b0;
        step("exwait_br", 6'b000000, 1'b1, 32'h200, S_EXW, 1'b1, 1'b0);
        branch_target_i = 32'h0000_0204;
        step("fl_br", 6'b000000, 1'b1, 32'h204, S_FL, 1'b1, 1'b0);
        branch_flag_i = 1'b0;
        step("fl_stay", 6'b000000, 1'b0, 32'h0, S_FL, 1'b1, 1'b0);
        step("fl_run", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        stallreq_ex_i = 1'b1;
        for (int k = 1; k <= 70; k++)
            step("ex_long", 6'b001111, 1'b0, 32'h0, (k == 1) ? S_RUN : S_EXW, 1'b1, (k >= 66));
        stallreq_ex_i = 1'b0;
        step("long_fall", 6'b000000, 1'b0, 32'h0, S_EXW, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            step("tmo_sticky", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b1);

        stallreq_ex_i = 1'b1;
        step("pre_rst0", 6'b001111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b1);
        step("pre_rst1", 6'b001111, 1'b0, 32'h0, S_EXW, 1'b1, 1'b1);
        rst = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h0000_0500;
        step("rst_exwait", 6'b000000, 1'b0, 32'h0, S_EXW, 1'b1, 1'b1);
        rst = 1'b0; clr();
        step("post_rst", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        branch_flag_i = 1'b1; branch_target_i = 32'h0000_0040;
        step("br2", 6'b000000, 1'b1, 32'h40, S_RUN, 1'b1, 1'b0);
        branch_flag_i = 1'b0; rst = 1'b1;
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd9; id_re2_i = 1'b1; id_ra2_i = 5'd9;
        step("rst_fl", 6'b000000, 1'b0, 32'h0, S_FL, 1'b1, 1'b0);
        rst = 1'b0;
        step("lu_post_rst", 6'b000111, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);
        clr();
        step("final_idle", 6'b000000, 1'b0, 32'h0, S_RUN, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
